// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline control unit.
// FSM states, scoreboard entry layout and fixed stage indices.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    // Entries carry rd at a fixed width; narrower register files zero-extend.
    localparam int REG_ADDR_MAX = 8;
    typedef logic [REG_ADDR_MAX-1:0] reg_t;

    typedef struct packed {
        logic valid;
        reg_t rd;
        logic we;
        logic halt;
    } sb_entry_t;

    localparam int IF_STG = 0;
    localparam int ID_STG = 1;

endpackage

// File: rtl/pipe_ctl_if.sv
// pipe_ctl_if: ID-side inputs and control outputs of pipe_ctl.
// master = datapath side, slave = pipe_ctl.
interface pipe_ctl_if #(
    parameter int STAGES       = 5,
    parameter int REG_ADDR_LEN = 5,
    parameter int CNT_W        = 32
);
    logic                    id_valid;
    logic [REG_ADDR_LEN-1:0] id_rs1;
    logic [REG_ADDR_LEN-1:0] id_rs2;
    logic                    id_rs1_use;
    logic                    id_rs2_use;
    logic [REG_ADDR_LEN-1:0] id_rd;
    logic                    id_rd_we;
    logic                    id_halt;
    logic                    br_taken;

    logic                    fetch_en;
    logic                    stall;
    logic [STAGES-1:0]       flush;
    logic [STAGES-1:0]       stage_valid;
    logic                    halt;
    logic [CNT_W-1:0]        perf_cycles;
    logic [CNT_W-1:0]        perf_retired;
    logic [CNT_W-1:0]        perf_stalls;
    logic [CNT_W-1:0]        perf_flushes;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use,
        output id_rd, id_rd_we, id_halt, br_taken,
        input  fetch_en, stall, flush, stage_valid, halt,
        input  perf_cycles, perf_retired, perf_stalls, perf_flushes
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use,
        input  id_rd, id_rd_we, id_halt, br_taken,
        output fetch_en, stall, flush, stage_valid, halt,
        output perf_cycles, perf_retired, perf_stalls, perf_flushes
    );

endinterface

// File: rtl/pipe_sb_entry.sv
// pipe_sb_entry: one scoreboard stage register with kill/bubble
// and a RAW match against the ID source registers.
module pipe_sb_entry
    import pipe_pkg::*;
#(
    parameter bit HAZ_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      kill,
    input  sb_entry_t in_e,
    input  reg_t      rs1,
    input  reg_t      rs2,
    input  logic      rs1_use,
    input  logic      rs2_use,
    output sb_entry_t q,
    output logic      match
);

    always_ff @(posedge clk) begin
        if (rst || kill) q <= '0;
        else             q <= in_e;
    end

    assign match = HAZ_EN && q.valid && q.we && (q.rd != '0) &&
                   ((rs1_use && (q.rd == rs1)) ||
                    (rs2_use && (q.rd == rs2)));

endmodule

// File: rtl/pipe_ctl.sv
// pipe_ctl: stall/flush/halt control for a STAGES-deep in-order pipeline.
// Define PIPE_PERF_EN to build the perf_* counters; otherwise they read 0.
module pipe_ctl
    import pipe_pkg::*;
#(
    parameter int STAGES       = 5,
    parameter int BR_STAGE     = 2,
    parameter int REG_ADDR_LEN = 5,
    parameter int CNT_W        = 32
) (
    input logic       clk,
    input logic       rst,
    pipe_ctl_if.slave bus
);

    localparam int WB_STG = STAGES - 1;
    localparam logic [STAGES-1:0] BR_MASK =
        STAGES'((64'd1 << BR_STAGE) - 64'd1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        fe_valid;
    sb_entry_t         sb [2:WB_STG];
    sb_entry_t         id_entry;
    logic [WB_STG:2]   hit;
    logic [STAGES-1:0] flush;
    logic [STAGES-1:0] stage_valid;
    logic              stall;
    logic              fetch_en;
    logic              load;
    logic              br;
    logic              halt_killed;
    reg_t              rs1;
    reg_t              rs2;

    assign br       = bus.br_taken;
    assign rs1      = reg_t'(bus.id_rs1);
    assign rs2      = reg_t'(bus.id_rs2);
    assign flush    = br ? BR_MASK : '0;
    assign stall    = bus.id_valid && (state == RUN) && !br && (|hit);
    assign fetch_en = (state == RUN) && !stall;
    assign load     = bus.id_valid && !stall && !flush[ID_STG] &&
                      (state == RUN);

    always_comb begin
        id_entry       = '0;
        id_entry.valid = 1'b1;
        id_entry.rd    = reg_t'(bus.id_rd);
        id_entry.we    = bus.id_rd_we;
        id_entry.halt  = bus.id_halt;
    end

    // WB is never compared: the register file is write-first.
    for (genvar s = 2; s <= WB_STG; s++) begin : g_sb
        sb_entry_t in_e;
        logic      kill;
        if (s == 2) begin : g_head
            assign in_e = id_entry;
            assign kill = !load;
        end else begin : g_tail
            assign in_e = sb[s-1];
            assign kill = flush[s-1];
        end
        pipe_sb_entry #(
            .HAZ_EN (s < WB_STG)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .kill    (kill),
            .in_e    (in_e),
            .rs1     (rs1),
            .rs2     (rs2),
            .rs1_use (bus.id_rs1_use),
            .rs2_use (bus.id_rs2_use),
            .q       (sb[s]),
            .match   (hit[s])
        );
    end

    always_comb begin
        halt_killed = 1'b0;
        for (int s = 2; s < BR_STAGE; s++) begin
            if (sb[s].valid && sb[s].halt) halt_killed = br;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (load && bus.id_halt) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (sb[WB_STG].valid && sb[WB_STG].halt)
                    state_nxt = HALTED;
                else if (halt_killed)
                    state_nxt = RUN;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fe_valid <= '0;
        end else begin
            fe_valid[IF_STG] <= !flush[IF_STG] &&
                (fetch_en || (stall && fe_valid[IF_STG]));
            fe_valid[ID_STG] <= !flush[ID_STG] &&
                (stall ? fe_valid[ID_STG] : fe_valid[IF_STG]);
        end
    end

    always_comb begin
        stage_valid = '0;
        if (state != HALTED) begin
            stage_valid[1:0] = fe_valid;
            for (int s = 2; s <= WB_STG; s++) begin
                stage_valid[s] = sb[s].valid;
            end
        end
    end

    assign bus.fetch_en    = fetch_en;
    assign bus.stall       = stall;
    assign bus.flush       = flush;
    assign bus.stage_valid = stage_valid;
    assign bus.halt        = (state == HALTED);

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] c_cycles;
    logic [CNT_W-1:0] c_retired;
    logic [CNT_W-1:0] c_stalls;
    logic [CNT_W-1:0] c_flushes;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_cycles  <= '0;
            c_retired <= '0;
            c_stalls  <= '0;
            c_flushes <= '0;
        end else if (state != HALTED) begin
            c_cycles <= c_cycles + CNT_W'(1);
            if (sb[WB_STG].valid) c_retired <= c_retired + CNT_W'(1);
            if (stall)            c_stalls  <= c_stalls + CNT_W'(1);
            if (br)               c_flushes <= c_flushes + CNT_W'(1);
        end
    end

    assign bus.perf_cycles  = c_cycles;
    assign bus.perf_retired = c_retired;
    assign bus.perf_stalls  = c_stalls;
    assign bus.perf_flushes = c_flushes;
`else
    assign bus.perf_cycles  = '0;
    assign bus.perf_retired = '0;
    assign bus.perf_stalls  = '0;
    assign bus.perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// tb_pipe_ctl: self-checking bench for pipe_ctl (5-stage and 6-stage builds).
// Perf expectations follow PIPE_PERF_EN when it is defined.
module tb_pipe_ctl;
    import pipe_pkg::*;

`ifdef PIPE_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edges = 0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    pipe_ctl_if #(.STAGES(5), .REG_ADDR_LEN(5), .CNT_W(32)) a ();
    pipe_ctl_if #(.STAGES(6), .REG_ADDR_LEN(5), .CNT_W(32)) b ();

    pipe_ctl #(
        .STAGES(5), .BR_STAGE(2), .REG_ADDR_LEN(5), .CNT_W(32)
    ) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    pipe_ctl #(
        .STAGES(6), .BR_STAGE(3), .REG_ADDR_LEN(5), .CNT_W(32)
    ) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    task automatic clr_in();
        a.id_valid = 0; a.id_rs1 = 0; a.id_rs2 = 0;
        a.id_rs1_use = 0; a.id_rs2_use = 0; a.id_rd = 0;
        a.id_rd_we = 0; a.id_halt = 0; a.br_taken = 0;
        b.id_valid = 0; b.id_rs1 = 0; b.id_rs2 = 0;
        b.id_rs1_use = 0; b.id_rs2_use = 0; b.id_rd = 0;
        b.id_rd_we = 0; b.id_halt = 0; b.br_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        edges = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (a.halt !== 1'b0) $display("FAIL rst_halt got %b want 0", a.halt);
        else passed++;
        total++;
        if (a.stall !== 1'b0) $display("FAIL rst_stall got %b want 0", a.stall);
        else passed++;
        total++;
        if (a.fetch_en !== 1'b1) $display("FAIL rst_fetch got %b want 1", a.fetch_en);
        else passed++;
        total++;
        if (a.stage_valid !== 5'b0)
            $display("FAIL rst_valid got %b want 00000", a.stage_valid);
        else passed++;
        total++;
        if (a.flush !== 5'b0) $display("FAIL rst_flush got %b want 00000", a.flush);
        else passed++;
        total++;
        if ({a.perf_cycles, a.perf_retired, a.perf_stalls, a.perf_flushes} !== 128'd0)
            $display("FAIL rst_perf got %0d/%0d/%0d/%0d want 0", a.perf_cycles,
                     a.perf_retired, a.perf_stalls, a.perf_flushes);
        else passed++;
        total++;
        if (b.stage_valid !== 6'b0 || b.halt !== 1'b0)
            $display("FAIL rst_dut6 got %b/%b want 000000/0", b.stage_valid, b.halt);
        else passed++;
    endtask

    task automatic test_raw();
        logic [31:0] st0;
        int n;
        do_reset();
        st0 = a.perf_stalls;
        a.id_valid = 1; a.id_rd = 3; a.id_rd_we = 1;
        #1;
        total++;
        if (a.stall !== 1'b0) $display("FAIL raw_prod got %b want 0", a.stall);
        else passed++;
        tick();
        a.id_rd = 4; a.id_rs1 = 3; a.id_rs1_use = 1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (!a.stall) break;
            n++;
            total++;
            if (a.fetch_en !== 1'b0)
                $display("FAIL raw_fetch got %b want 0", a.fetch_en);
            else passed++;
            tick();
        end
        total++;
        if (n != 2) $display("FAIL raw_stall_len got %0d want 2", n);
        else passed++;
        tick();
        total++;
        if (a.stage_valid[2] !== 1'b1)
            $display("FAIL raw_advance got %b want 1", a.stage_valid[2]);
        else passed++;
        total++;
        if (a.perf_stalls - st0 !== 32'(2 * PERF))
            $display("FAIL raw_perf got %0d want %0d", a.perf_stalls - st0, 2 * PERF);
        else passed++;
        a.id_rd = 0; a.id_rs1_use = 0;
        tick();
        a.id_rs1 = 0; a.id_rs1_use = 1; a.id_rd = 6;
        #1;
        total++;
        if (a.stall !== 1'b0) $display("FAIL raw_x0 got %b want 0", a.stall);
        else passed++;
        tick();
        a.id_rs1_use = 0; a.id_rs2 = 6; a.id_rs2_use = 1; a.id_rd = 0;
        #1;
        total++;
        if (a.stall !== 1'b1) $display("FAIL raw_rs2 got %b want 1", a.stall);
        else passed++;
        a.id_rs2_use = 0;
        #1;
        total++;
        if (a.stall !== 1'b0) $display("FAIL raw_nouse got %b want 0", a.stall);
        else passed++;
        clr_in();
    endtask

    task automatic test_branch();
        logic [31:0] f0;
        do_reset();
        a.id_valid = 1; a.id_rd = 0; a.id_rd_we = 1;
        repeat (3) tick();
        f0 = a.perf_flushes;
        a.br_taken = 1;
        #1;
        total++;
        if (a.flush !== 5'b00011) $display("FAIL br_flush got %b want 00011", a.flush);
        else passed++;
        tick();
        a.br_taken = 0;
        #1;
        total++;
        if (a.stage_valid[2:0] !== 3'b000)
            $display("FAIL br_kill got %b want 000", a.stage_valid[2:0]);
        else passed++;
        total++;
        if (a.flush !== 5'b0) $display("FAIL br_flush_off got %b want 00000", a.flush);
        else passed++;
        total++;
        if (a.perf_flushes - f0 !== 32'(PERF))
            $display("FAIL br_perf got %0d want %0d", a.perf_flushes - f0, PERF);
        else passed++;
        clr_in();
    endtask

    task automatic test_branch_stall();
        logic [31:0] s0;
        do_reset();
        a.id_valid = 1; a.id_rd = 5; a.id_rd_we = 1;
        tick();
        a.id_rd = 0; a.id_rs1 = 5; a.id_rs1_use = 1;
        #1;
        total++;
        if (a.stall !== 1'b1) $display("FAIL bs_pre got %b want 1", a.stall);
        else passed++;
        s0 = a.perf_stalls;
        a.br_taken = 1;
        #1;
        total++;
        if (a.stall !== 1'b0 || a.fetch_en !== 1'b1)
            $display("FAIL bs_override got %b/%b want 0/1", a.stall, a.fetch_en);
        else passed++;
        tick();
        clr_in();
        #1;
        total++;
        if (a.perf_stalls !== s0)
            $display("FAIL bs_perf got %0d want %0d", a.perf_stalls, s0);
        else passed++;
        total++;
        if (a.stage_valid[3:2] !== 2'b10)
            $display("FAIL bs_drop got %b want 10", a.stage_valid[3:2]);
        else passed++;
    endtask

    task automatic test_stream();
        int q[$];
        int issued;
        logic exp;
        do_reset();
        issued = 0;
        for (int i = 0; i < 70; i++) begin
            if (i < 60) begin
                a.id_valid = ($urandom_range(0, 3) != 0);
                a.id_rd = 5'($urandom_range(1, 31));
                a.id_rd_we = 1;
                a.br_taken = ($urandom_range(0, 7) == 0);
                if (a.id_valid && !a.br_taken) begin
                    q.push_back(edges + 3);
                    issued++;
                end
            end else begin
                clr_in();
            end
            #1;
            exp = (q.size() > 0) && (q[0] == edges);
            if (exp) void'(q.pop_front());
            total++;
            if (a.stage_valid[4] !== exp)
                $display("FAIL retire_wb cyc %0d got %b want %b", edges,
                         a.stage_valid[4], exp);
            else passed++;
            tick();
        end
        total++;
        if (q.size() != 0) $display("FAIL stream_left got %0d want 0", q.size());
        else passed++;
        total++;
        if (a.perf_retired !== 32'(issued * PERF))
            $display("FAIL stream_perf got %0d want %0d", a.perf_retired, issued * PERF);
        else passed++;
    endtask

    task automatic test_halt();
        logic [31:0] cyc;
        do_reset();
        a.id_valid = 1; a.id_rd = 7; a.id_rd_we = 1;
        tick();
        a.id_halt = 1; a.id_rd_we = 0; a.id_rd = 0;
        a.id_rs1 = 7; a.id_rs1_use = 1;
        #1;
        total++;
        if (a.stall !== 1'b1 || a.fetch_en !== 1'b0)
            $display("FAIL halt_stall got %b/%b want 1/0", a.stall, a.fetch_en);
        else passed++;
        tick();
        total++;
        if (a.stall !== 1'b1 || a.stage_valid[2] !== 1'b0)
            $display("FAIL halt_hold got %b/%b want 1/0", a.stall, a.stage_valid[2]);
        else passed++;
        tick();
        total++;
        if (a.stall !== 1'b0 || a.fetch_en !== 1'b1)
            $display("FAIL halt_go got %b/%b want 0/1", a.stall, a.fetch_en);
        else passed++;
        tick();
        a.id_halt = 0; a.id_rs1_use = 0; a.id_rd = 9; a.id_rd_we = 1;
        #1;
        total++;
        if (a.fetch_en !== 1'b0 || a.halt !== 1'b0)
            $display("FAIL halt_drain got %b/%b want 0/0", a.fetch_en, a.halt);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (a.halt !== (k == 3))
                $display("FAIL halt_rise k=%0d got %b want %b", k, a.halt, k == 3);
            else passed++;
        end
        total++;
        if (a.stage_valid !== 5'b0)
            $display("FAIL halt_valid got %b want 00000", a.stage_valid);
        else passed++;
        total++;
        if (a.perf_cycles !== 32'(edges * PERF))
            $display("FAIL halt_cyc got %0d want %0d", a.perf_cycles, edges * PERF);
        else passed++;
        total++;
        if (a.perf_retired !== 32'(2 * PERF))
            $display("FAIL halt_ret got %0d want %0d", a.perf_retired, 2 * PERF);
        else passed++;
        cyc = a.perf_cycles;
        repeat (5) tick();
        total++;
        if (a.halt !== 1'b1 || a.fetch_en !== 1'b0 || a.perf_cycles !== cyc)
            $display("FAIL halt_sticky got %b/%b/%0d want 1/0/%0d", a.halt,
                     a.fetch_en, a.perf_cycles, cyc);
        else passed++;
        clr_in();
    endtask

    task automatic test_halt_kill();
        do_reset();
        b.id_valid = 1; b.id_halt = 1;
        #1;
        total++;
        if (b.fetch_en !== 1'b1) $display("FAIL hk_run got %b want 1", b.fetch_en);
        else passed++;
        tick();
        b.id_halt = 0; b.br_taken = 1;
        #1;
        total++;
        if (b.flush !== 6'b000111 || b.fetch_en !== 1'b0)
            $display("FAIL hk_flush got %b/%b want 000111/0", b.flush, b.fetch_en);
        else passed++;
        tick();
        b.br_taken = 0; b.id_valid = 0;
        #1;
        total++;
        if (b.fetch_en !== 1'b1 || b.stage_valid[3] !== 1'b0)
            $display("FAIL hk_back got %b/%b want 1/0", b.fetch_en, b.stage_valid[3]);
        else passed++;
        repeat (6) tick();
        total++;
        if (b.halt !== 1'b0) $display("FAIL hk_nohalt got %b want 0", b.halt);
        else passed++;
        b.id_valid = 1; b.id_halt = 1;
        tick();
        b.id_valid = 0; b.id_halt = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (b.halt !== (k == 4))
                $display("FAIL hk_rise k=%0d got %b want %b", k, b.halt, k == 4);
            else passed++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        clr_in();
        test_reset();
        test_raw();
        test_branch();
        test_branch_stall();
        test_stream();
        test_halt();
        test_halt_kill();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_ctl.md
# pipe_ctl

Parametrised pipeline control unit for the in-order processor core, sitting beside the IF…WB datapath and driving its stall, flush and halt controls. It generalises the fixed five-stage hookup to STAGES stages with a configurable branch-resolve point. It tracks per-stage valid/destination/halt state to detect RAW hazards against ID, kill wrong-path instructions, and drain the pipeline cleanly before asserting halt.

## Interface
- STAGES, 5: pipeline depth, ≥4; stage 0 = IF, 1 = ID, STAGES-1 = WB
- BR_STAGE, 2: stage where br_taken is resolved, 2..STAGES-2
- REG_ADDR_LEN, 5: register address width; register 0 never hazards
- CNT_W, 32: performance counter width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_LEN  ID source registers
- id_rs1_use, id_rs2_use  in  1  source actually read
- id_rd  in  REG_ADDR_LEN  ID destination register
- id_rd_we  in  1  ID instruction writes id_rd
- id_halt  in  1  ID instruction is HALT
- br_taken  in  1  taken branch/jump in stage BR_STAGE
- fetch_en  out  1  IF may fetch and advance PC
- stall  out  1  hold IF and IF/ID; inject bubble into ID/EXE
- flush  out  STAGES  per-stage kill mask, bit i kills stage i
- stage_valid  out  STAGES  valid bit per stage, after flush
- halt  out  1  pipeline drained on HALT; sticky until rst
- perf_cycles, perf_retired, perf_stalls, perf_flushes  out  CNT_W each  counters

## Operation
- Scoreboard: entries for stages 2..STAGES-1, each {valid, rd, we, halt}; shift one stage per cycle unconditionally (no back-pressure below ID).
- Entry into stage 2: copy of ID fields when id_valid && !stall && !flush[1] && state==RUN; otherwise bubble (valid=0).
- Hazard: stall = id_valid && state==RUN && !br_taken && any stage s in 2..STAGES-2 with valid && we && rd!=0 && ((id_rs1_use && rd==id_rs1) || (id_rs2_use && rd==id_rs2)).
- WB (STAGES-1) never compared: register file is write-first, WB data visible to ID same cycle.
- Branch: br_taken sets flush[0..BR_STAGE-1]=1, all other bits 0; killed scoreboard entries cleared same edge. Branch overrides stall.
- Stages 0/1 valid tracked internally: set by fetch_en, held on stall, cleared by flush.
- FSM RUN/DRAIN/HALTED:
  - RUN→DRAIN: HALT entry written into stage 2.
  - DRAIN→RUN: HALT entry killed by flush (only possible if BR_STAGE>2).
  - DRAIN→HALTED: HALT entry valid in stage STAGES-1.
  - HALTED: exits only via rst.
- fetch_en = (state==RUN) && !stall. In DRAIN older instructions complete normally.
- halt = (state==HALTED); all stage_valid 0 in HALTED.
- Retire: valid entry in stage STAGES-1, HALT included.

## Timing
- Reset (rst sampled high): state RUN, all valids 0, flush 0, stall 0, halt 0, fetch_en 1, counters 0.
- stall, flush, fetch_en are combinational from current inputs/scoreboard, same cycle.
- Back-to-back dependent pair (producer in stage 2): stall for STAGES-3 cycles (2 for STAGES=5).
- halt rises STAGES-2 cycles after HALT leaves ID (3 for STAGES=5).
- br_taken with stall same cycle: stall=0, flush applied, ID instruction dropped.
- id_halt while stalled: HALT stays in ID, no transition.
- rst mid-DRAIN: returns to RUN, scoreboard cleared, next edge.

## Configuration
- PIPE_PERF_EN defined: perf_* count each cycle not in HALTED / each retire / each stall cycle / each br_taken cycle; wrap modulo 2^CNT_W; freeze in HALTED.
- Undefined: counter logic absent, perf_* tied to 0.

## Structure
- Shared package pipe_pkg: FSM state enum (RUN, DRAIN, HALTED), scoreboard entry struct {valid, rd, we, halt}, stage index constants IF_STG=0, ID_STG=1.
- One sub-module pipe_sb_entry: single scoreboard entry register with kill, bubble and hazard-match output; instantiated STAGES-2 times by generate.

## Test plan
- Reset: rst high 2 cycles → halt=0, stall=0, fetch_en=1, stage_valid=0, perf_*=0.
- RAW: ID rd=3 we=1, next ID rs1=3 use=1 (STAGES=5) → stall=1 exactly 2 cycles, then advances; rd=0 producer → no stall.
- Branch: br_taken=1 at BR_STAGE=2 → flush=5'b00011 one cycle, stage_valid[1:0]=0 next cycle, perf_flushes +1.
- Branch + stall same cycle → stall=0, stall counter unchanged.
- HALT: HALT leaves ID at cycle t → fetch_en=0 from t+1, halt=1 at t+3 and sticky, perf_retired counts HALT, counters freeze.
- BR_STAGE=3, STAGES=6: HALT in stage 2 when br_taken → HALT killed, state back to RUN, halt stays 0.
